mpq_result_checker: RTL and testbench
=====================================

MPQ_RESULT_CHECKER -- requirements
Module: mpq_result_checker

Interface
REQ-001 SHALL have parameter: DATA_W, 8, key width matching the priority-queue RAM_D bus.
REQ-002 SHALL have parameter: ADDR_W, 8, address width matching the priority-queue RAM_A bus; the memory depth SHALL be 2**ADDR_W.
REQ-003 SHALL have port: clk  in  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: RAM_valid  in  1 / RAM_A  in  ADDR_W / RAM_D  in  DATA_W / done  in  1, all driven by the upstream priority-queue write-out.
REQ-006 SHALL have ports: rd_en  in  1 / rd_addr  in  ADDR_W, the readback request.
REQ-007 SHALL have ports: rd_valid  out  1 / rd_data  out  DATA_W, the readback response.
REQ-008 SHALL have ports: chk_busy  out  1 / chk_done  out  1 / heap_ok  out  1 / bad_idx  out  ADDR_W / count  out  ADDR_W+1.

Function
REQ-009 SHALL implement states IDLE, CAPTURE, CHECK, REPORT.
REQ-010 SHALL treat a write as valid only when RAM_valid=1 and done=0; on a valid write mem[RAM_A] SHALL be set to RAM_D.
REQ-011 IDLE: a valid write SHALL clear count, perform the write, and enter CAPTURE.
REQ-012 CAPTURE: each valid write SHALL update count to max(count, RAM_A+1).
REQ-013 A done rising edge, sampled in cycle E while in IDLE or CAPTURE, SHALL start a check.
REQ-014 The check SHALL enter CHECK with i=1 if count>=2, else REPORT directly.
REQ-015 A level-high done without an edge SHALL NOT start a new check.
REQ-016 CHECK: one index SHALL be checked per cycle, with parent=(i-1)>>1.
REQ-017 CHECK violation: if mem[i] > mem[parent] (unsigned), the block SHALL latch heap_ok=0 and bad_idx=i, then go to REPORT next cycle (early exit).
REQ-018 CHECK pass: if i=count-1 without violation, the block SHALL latch heap_ok=1 and bad_idx=0, then go to REPORT.
REQ-019 chk_done SHALL assert in cycle E+max(count,1) on pass, or E+i+1 on violation at index i.
REQ-020 REPORT SHALL last exactly one cycle with chk_done=1, then return to IDLE.
REQ-021 heap_ok and bad_idx SHALL hold until the next check completes.
REQ-022 chk_busy SHALL be 1 in CHECK and REPORT, else 0.
REQ-023 Valid writes arriving in CHECK or REPORT SHALL be dropped.
REQ-024 count SHALL be ADDR_W+1 bits; 256 entries SHALL be representable without wrap.
REQ-025 Readback: rd_en=1 outside CHECK SHALL give rd_data=mem[rd_addr] and rd_valid=1 in the next cycle.
REQ-026 rd_en during CHECK SHALL be ignored, with rd_valid=0.
REQ-027 rd_valid SHALL be a one-cycle pulse per accepted request.
REQ-028 A read and a valid write to the same address in the same cycle SHALL return the old data (read-before-write).

Reset
REQ-029 rst_n=0 SHALL asynchronously force state=IDLE and count=0.
REQ-030 rst_n=0 SHALL clear chk_busy, chk_done, heap_ok, bad_idx, rd_valid, rd_data and the done edge-detect register.
REQ-031 Memory contents SHALL NOT be reset and are undefined until written.
REQ-032 Reset mid-CHECK SHALL abandon the check with no chk_done pulse.

Structure
REQ-033 Shared package mpq_pkg SHALL hold DATA_W, ADDR_W, the state encoding, and the MPQ command codes (BUILD=0, EXTRACT=1, INCREASE=2, INSERT=3, WRITE=4).
REQ-034 Sub-module mpq_result_mem SHALL contain the register-array storage: one write port, two combinational read ports (child/parent), and one registered read port (readback).

Verification
REQ-035 Bench SHALL cover: writes [9,7,8,3,5] to addr 0..4, then done rises at E -> count=5, heap_ok=1, bad_idx=0, chk_done at E+5.
REQ-036 Bench SHALL cover: writes [9,7,8,10], then done -> heap_ok=0, bad_idx=3, chk_done at E+4.
REQ-037 Bench SHALL cover: done rising with no prior writes -> count=0, heap_ok=1, chk_done at E+1.
REQ-038 Bench SHALL cover: after REQ-035, RAM_valid=1, RAM_A=2, RAM_D=99 held with done=1 -> write ignored, and rd_addr=2 returns rd_data=8 one cycle later.
REQ-039 Bench SHALL cover: 256 writes to addr 0..255 in descending values -> count=256, heap_ok=1, chk_done at E+256.
REQ-040 Bench SHALL cover: rst_n pulled low at E+2 of the REQ-035 scenario -> all outputs 0 immediately, no chk_done, state IDLE.

Source files
------------

// File: rtl/mpq_pkg.sv
// Shared definitions for the priority-queue result checker: bus widths, checker
// state encoding and the MPQ command codes used by the upstream queue.
package mpq_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StCheck   = 2'd2,
        StReport  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        CmdBuild    = 3'd0,
        CmdExtract  = 3'd1,
        CmdIncrease = 3'd2,
        CmdInsert   = 3'd3,
        CmdWrite    = 3'd4
    } mpq_cmd_e;

endpackage

// File: rtl/mpq_result_checker_if.sv
// Bundle of the write-out capture, readback and check-status signals of the
// result checker.
interface mpq_result_checker_if #(
    parameter int unsigned DATA_W = mpq_pkg::DATA_W,
    parameter int unsigned ADDR_W = mpq_pkg::ADDR_W
);
    logic              RAM_valid;
    logic [ADDR_W-1:0] RAM_A;
    logic [DATA_W-1:0] RAM_D;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              chk_busy;
    logic              chk_done;
    logic              heap_ok;
    logic [ADDR_W-1:0] bad_idx;
    logic [ADDR_W:0]   count;

    modport master (
        output RAM_valid, RAM_A, RAM_D, done, rd_en, rd_addr,
        input  rd_valid, rd_data, chk_busy, chk_done, heap_ok, bad_idx, count
    );

    modport slave (
        input  RAM_valid, RAM_A, RAM_D, done, rd_en, rd_addr,
        output rd_valid, rd_data, chk_busy, chk_done, heap_ok, bad_idx, count
    );

endinterface

// File: rtl/mpq_result_mem.sv
// Capture storage: one write port, combinational child/parent read ports for the
// heap walk, and a registered readback port that returns pre-write data.
module mpq_result_mem #(
    parameter int unsigned DATA_W = mpq_pkg::DATA_W,
    parameter int unsigned ADDR_W = mpq_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] child_addr,
    output logic [DATA_W-1:0] child_data,
    input  logic [ADDR_W-1:0] parent_addr,
    output logic [DATA_W-1:0] parent_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [Depth];
    logic [DATA_W-1:0] rd_data_q;

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rd_data_q <= '0;
        else if (rd_en) rd_data_q <= mem_q[rd_addr];
    end

    assign child_data  = mem_q[child_addr];
    assign parent_data = mem_q[parent_addr];
    assign rd_data     = rd_data_q;

endmodule

// File: rtl/mpq_result_checker.sv
// Captures the priority-queue write-out and, on a rising done, walks the array
// once to verify the max-heap property, reporting the first offending index.
module mpq_result_checker #(
    parameter int unsigned DATA_W = mpq_pkg::DATA_W,
    parameter int unsigned ADDR_W = mpq_pkg::ADDR_W
) (
    input logic                 clk,
    input logic                 rst_n,
    mpq_result_checker_if.slave bus
);
    import mpq_pkg::*;

    typedef logic [ADDR_W:0] cnt_t;

    state_e            state_q, state_d;
    cnt_t              count_q, count_d;
    logic [ADDR_W-1:0] idx_q, idx_d, parent_idx;
    logic [ADDR_W-1:0] bad_idx_q, bad_idx_d;
    logic              heap_ok_q, heap_ok_d;
    logic              done_q, rd_valid_q;
    logic [DATA_W-1:0] child_key, parent_key;
    logic              wr_valid, wr_en, done_rise, rd_accept, is_last;
    cnt_t              wr_extent;

    assign wr_valid   = bus.RAM_valid & ~bus.done;
    assign wr_en      = wr_valid & ((state_q == StIdle) | (state_q == StCapture));
    assign done_rise  = bus.done & ~done_q;
    assign rd_accept  = bus.rd_en & (state_q != StCheck);
    assign parent_idx = (idx_q - ADDR_W'(1)) >> 1;
    assign wr_extent  = {1'b0, bus.RAM_A} + cnt_t'(1);
    assign is_last    = ({1'b0, idx_q} == (count_q - cnt_t'(1)));

    mpq_result_mem #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (wr_en),
        .waddr      (bus.RAM_A),
        .wdata      (bus.RAM_D),
        .child_addr (idx_q),
        .child_data (child_key),
        .parent_addr(parent_idx),
        .parent_data(parent_key),
        .rd_en      (rd_accept),
        .rd_addr    (bus.rd_addr),
        .rd_data    (bus.rd_data)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        heap_ok_d = heap_ok_q;
        bad_idx_d = bad_idx_q;
        case (state_q)
            StIdle, StCapture: begin
                if (done_rise) begin
                    if (count_q >= cnt_t'(2)) begin
                        state_d = StCheck;
                        idx_d   = ADDR_W'(1);
                    end else begin
                        state_d   = StReport;
                        heap_ok_d = 1'b1;
                        bad_idx_d = '0;
                    end
                end else if (wr_valid) begin
                    state_d = StCapture;
                    // The first write of a new capture restarts the extent.
                    if ((state_q == StIdle) || (wr_extent > count_q)) count_d = wr_extent;
                end
            end
            StCheck: begin
                if (child_key > parent_key) begin
                    state_d   = StReport;
                    heap_ok_d = 1'b0;
                    bad_idx_d = idx_q;
                end else if (is_last) begin
                    state_d   = StReport;
                    heap_ok_d = 1'b1;
                    bad_idx_d = '0;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            StReport: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            count_q    <= '0;
            idx_q      <= '0;
            heap_ok_q  <= 1'b0;
            bad_idx_q  <= '0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            heap_ok_q  <= heap_ok_d;
            bad_idx_q  <= bad_idx_d;
            done_q     <= bus.done;
            rd_valid_q <= rd_accept;
        end
    end

    assign bus.chk_busy = (state_q == StCheck) | (state_q == StReport);
    assign bus.chk_done = (state_q == StReport);
    assign bus.heap_ok  = heap_ok_q;
    assign bus.bad_idx  = bad_idx_q;
    assign bus.count    = count_q;
    assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_mpq_result_checker.sv
// Directed bench for mpq_result_checker: heap pass/fail, empty check, level done,
// readback ordering, full 256-entry walk and reset during a check.
module tb_mpq_result_checker;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mpq_result_checker_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    mpq_result_checker #(
        .DATA_W(8),
        .ADDR_W(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.RAM_valid = 1'b0;
        bus.done = 1'b0;
        bus.rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wr(input int a, input int d);
        bus.RAM_valid = 1'b1;
        bus.RAM_A = 8'(a);
        bus.RAM_D = 8'(d);
        tick();
        bus.RAM_valid = 1'b0;
    endtask

    // Raises done and counts cycles until chk_done is seen; -1 if it never is.
    task automatic fire_and_wait(input int budget, output int lat);
        bus.RAM_valid = 1'b0;
        bus.done = 1'b1;
        lat = -1;
        for (int n = 1; n <= budget; n++) begin
            tick();
            if (bus.chk_done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.RAM_valid = 1'b0;
        bus.RAM_A = '0;
        bus.RAM_D = '0;
        bus.done = 1'b0;
        bus.rd_en = 1'b0;
        bus.rd_addr = '0;
        #3;
        total++;
        if ({bus.chk_busy, bus.chk_done, bus.heap_ok, bus.rd_valid} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0000",
                     {bus.chk_busy, bus.chk_done, bus.heap_ok, bus.rd_valid});
        end
        total++;
        if (bus.count !== 9'd0 || bus.bad_idx !== 8'd0 || bus.rd_data !== 8'd0) begin
            bad++;
            $display("FAIL reset_values: got count=%0d bad_idx=%0d rd_data=%0d want 0 0 0",
                     bus.count, bus.bad_idx, bus.rd_data);
        end
        do_reset();
    endtask

    task automatic test_empty();
        int lat;
        fire_and_wait(10, lat);
        total++;
        if (lat != 1) begin
            bad++;
            $display("FAIL empty_latency: got %0d want 1", lat);
        end
        total++;
        if (bus.count !== 9'd0 || bus.heap_ok !== 1'b1 || bus.bad_idx !== 8'd0) begin
            bad++;
            $display("FAIL empty_result: got count=%0d ok=%b idx=%0d want 0 1 0",
                     bus.count, bus.heap_ok, bus.bad_idx);
        end
        tick();
        total++;
        if (bus.chk_done !== 1'b0 || bus.chk_busy !== 1'b0) begin
            bad++;
            $display("FAIL empty_report_len: got done=%b busy=%b want 0 0",
                     bus.chk_done, bus.chk_busy);
        end
        bus.done = 1'b0;
        tick();
    endtask

    task automatic test_heap_pass();
        int lat;
        int vals [5] = '{9, 7, 8, 3, 5};
        do_reset();
        for (int a = 0; a < 5; a++) wr(a, vals[a]);
        total++;
        if (bus.count !== 9'd5) begin
            bad++;
            $display("FAIL pass_count: got %0d want 5", bus.count);
        end
        fire_and_wait(20, lat);
        total++;
        if (lat != 5) begin
            bad++;
            $display("FAIL pass_latency: got %0d want 5", lat);
        end
        total++;
        if (bus.heap_ok !== 1'b1 || bus.bad_idx !== 8'd0 || bus.chk_busy !== 1'b1) begin
            bad++;
            $display("FAIL pass_result: got ok=%b idx=%0d busy=%b want 1 0 1",
                     bus.heap_ok, bus.bad_idx, bus.chk_busy);
        end
        tick();
    endtask

    // Runs straight after test_heap_pass with done still high.
    task automatic test_level_done();
        bus.RAM_valid = 1'b1;
        bus.RAM_A = 8'd2;
        bus.RAM_D = 8'd99;
        bus.rd_en = 1'b1;
        bus.rd_addr = 8'd2;
        tick();
        bus.rd_en = 1'b0;
        total++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'd8) begin
            bad++;
            $display("FAIL level_rd0: got v=%b d=%0d want 1 8", bus.rd_valid, bus.rd_data);
        end
        for (int n = 0; n < 3; n++) begin
            tick();
            total++;
            if (bus.chk_done !== 1'b0 || bus.chk_busy !== 1'b0) begin
                bad++;
                $display("FAIL level_no_check: got done=%b busy=%b want 0 0",
                         bus.chk_done, bus.chk_busy);
            end
        end
        bus.RAM_valid = 1'b0;
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        total++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'd8) begin
            bad++;
            $display("FAIL level_write_dropped: got v=%b d=%0d want 1 8",
                     bus.rd_valid, bus.rd_data);
        end
        tick();
        total++;
        if (bus.rd_valid !== 1'b0 || bus.count !== 9'd5) begin
            bad++;
            $display("FAIL level_pulse: got v=%b count=%0d want 0 5", bus.rd_valid, bus.count);
        end
        bus.done = 1'b0;
        tick();
    endtask

    task automatic test_read_before_write();
        do_reset();
        wr(7, 8'h11);
        bus.RAM_valid = 1'b1;
        bus.RAM_A = 8'd7;
        bus.RAM_D = 8'h22;
        bus.rd_en = 1'b1;
        bus.rd_addr = 8'd7;
        tick();
        bus.RAM_valid = 1'b0;
        total++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h11) begin
            bad++;
            $display("FAIL rbw_old: got v=%b d=%h want 1 11", bus.rd_valid, bus.rd_data);
        end
        tick();
        bus.rd_en = 1'b0;
        total++;
        if (bus.rd_data !== 8'h22 || bus.count !== 9'd8) begin
            bad++;
            $display("FAIL rbw_new: got d=%h count=%0d want 22 8", bus.rd_data, bus.count);
        end
        tick();
    endtask

    task automatic test_violation();
        int lat;
        int vals [4] = '{9, 7, 8, 10};
        do_reset();
        for (int a = 0; a < 4; a++) wr(a, vals[a]);
        fire_and_wait(20, lat);
        total++;
        if (lat != 4) begin
            bad++;
            $display("FAIL viol_latency: got %0d want 4", lat);
        end
        total++;
        if (bus.heap_ok !== 1'b0 || bus.bad_idx !== 8'd3 || bus.count !== 9'd4) begin
            bad++;
            $display("FAIL viol_result: got ok=%b idx=%0d count=%0d want 0 3 4",
                     bus.heap_ok, bus.bad_idx, bus.count);
        end
        bus.done = 1'b0;
        repeat (3) tick();
        total++;
        if (bus.heap_ok !== 1'b0 || bus.bad_idx !== 8'd3) begin
            bad++;
            $display("FAIL viol_hold: got ok=%b idx=%0d want 0 3", bus.heap_ok, bus.bad_idx);
        end
    endtask

    task automatic test_full();
        int lat;
        do_reset();
        for (int a = 0; a < 256; a++) wr(a, 255 - a);
        total++;
        if (bus.count !== 9'd256) begin
            bad++;
            $display("FAIL full_count: got %0d want 256", bus.count);
        end
        bus.done = 1'b1;
        lat = -1;
        for (int n = 1; n <= 400; n++) begin
            tick();
            if (n >= 2 && n <= 4) begin
                total++;
                if (bus.rd_valid !== 1'b0 || bus.chk_busy !== 1'b1) begin
                    bad++;
                    $display("FAIL full_rd_ignored: got v=%b busy=%b want 0 1",
                             bus.rd_valid, bus.chk_busy);
                end
            end
            bus.rd_en = (n >= 1 && n <= 3);
            if (bus.chk_done === 1'b1) begin
                lat = n;
                break;
            end
        end
        bus.rd_en = 1'b0;
        total++;
        if (lat != 256 || bus.heap_ok !== 1'b1 || bus.bad_idx !== 8'd0) begin
            bad++;
            $display("FAIL full_result: got lat=%0d ok=%b idx=%0d want 256 1 0",
                     lat, bus.heap_ok, bus.bad_idx);
        end
        bus.done = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_check();
        int vals [5] = '{9, 7, 8, 3, 5};
        do_reset();
        for (int a = 0; a < 5; a++) wr(a, vals[a]);
        bus.done = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        bus.done = 1'b0;
        #1;
        total++;
        if ({bus.chk_busy, bus.chk_done, bus.heap_ok, bus.rd_valid} !== 4'b0000 ||
            bus.count !== 9'd0 || bus.bad_idx !== 8'd0) begin
            bad++;
            $display("FAIL midrst_outputs: got flags=%b count=%0d idx=%0d want 0000 0 0",
                     {bus.chk_busy, bus.chk_done, bus.heap_ok, bus.rd_valid},
                     bus.count, bus.bad_idx);
        end
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick();
            total++;
            if (bus.chk_done !== 1'b0 || bus.chk_busy !== 1'b0) begin
                bad++;
                $display("FAIL midrst_no_done: got done=%b busy=%b want 0 0",
                         bus.chk_done, bus.chk_busy);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b1;
        test_reset();
        test_empty();
        test_heap_pass();
        test_level_done();
        test_read_before_write();
        test_violation();
        test_full();
        test_reset_mid_check();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
